// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the core memory bus between instruction fetch (M0)
// and the load/store unit (M1). One transaction at a time, req/gnt
// handshake, registered owner, combinational data-path multiplexer, and a
// timeout that aborts transactions the slave never acknowledges.
// Optional build macro: BUS_ARB_ROUND_ROBIN_EN (alternate between masters
// when both request; default is fixed priority M1 over M0).
module bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_M0_REQ,
  input  logic [31:0] i_M0_ADDR,
  input  logic [31:0] i_M0_WDATA,
  input  logic        i_M0_WE,
  input  logic [1:0]  i_M0_HB,
  output logic        o_M0_GNT,
  output logic [31:0] o_M0_RDATA,
  input  logic        i_M1_REQ,
  input  logic [31:0] i_M1_ADDR,
  input  logic [31:0] i_M1_WDATA,
  input  logic        i_M1_WE,
  input  logic [1:0]  i_M1_HB,
  output logic        o_M1_GNT,
  output logic [31:0] o_M1_RDATA,
  output logic        o_BUS_REQ,
  output logic [31:0] o_BUS_ADDR,
  output logic [31:0] o_BUS_WDATA,
  output logic        o_BUS_WE,
  output logic [1:0]  o_BUS_HB,
  input  logic [31:0] i_BUS_RDATA,
  input  logic        i_BUS_ACK,
  output logic        o_BUS_ERR
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;   // 0: M0 served last, 1: M1 served last
  logic [CW-1:0] cnt_q, cnt_d;

  logic        pick_m1;
  logic        own_sel;            // 1 when M1 is the current owner
  logic        own_req;
  logic        gnt;
  logic [31:0] gnt_rdata;

  // Arbitration decision taken in IDLE.
  always_comb begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
    pick_m1 = i_M1_REQ && (!i_M0_REQ || !last_q);
`else
    pick_m1 = i_M1_REQ;
`endif
  end

  // Next-state, counter and all outputs; bus fields follow the owner.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    own_sel     = 1'b0;
    own_req     = 1'b0;
    gnt         = 1'b0;
    gnt_rdata   = 32'h0;
    o_BUS_REQ   = 1'b0;
    o_BUS_ADDR  = 32'h0;
    o_BUS_WDATA = 32'h0;
    o_BUS_WE    = 1'b0;
    o_BUS_HB    = 2'b00;
    o_BUS_ERR   = 1'b0;
    o_M0_GNT    = 1'b0;
    o_M0_RDATA  = 32'h0;
    o_M1_GNT    = 1'b0;
    o_M1_RDATA  = 32'h0;

    case (state_q)
      IDLE: begin
        // Counter is held at zero so every ownership starts from a clean count.
        cnt_d = '0;
        if (pick_m1) begin
          state_d = OWN_M1;
        end else if (i_M0_REQ) begin
          state_d = OWN_M0;
        end
      end
      OWN_M0, OWN_M1: begin
        own_sel     = (state_q == OWN_M1);
        own_req     = own_sel ? i_M1_REQ : i_M0_REQ;
        o_BUS_REQ   = own_req;
        o_BUS_ADDR  = own_sel ? i_M1_ADDR  : i_M0_ADDR;
        o_BUS_WDATA = own_sel ? i_M1_WDATA : i_M0_WDATA;
        o_BUS_WE    = own_sel ? i_M1_WE    : i_M0_WE;
        o_BUS_HB    = own_sel ? i_M1_HB    : i_M0_HB;
        if (!own_req) begin
          // Owner withdrew its request: abandon quietly, no grant, no error.
          state_d = IDLE;
        end else if (i_BUS_ACK) begin
          // ACK beats a simultaneous timeout.
          gnt       = 1'b1;
          gnt_rdata = i_BUS_RDATA;
          state_d   = IDLE;
          last_d    = own_sel;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          gnt       = 1'b1;
          gnt_rdata = ERR_RDATA;
          o_BUS_ERR = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (own_sel) begin
      o_M1_GNT   = gnt;
      o_M1_RDATA = gnt_rdata;
    end else begin
      o_M0_GNT   = gnt;
      o_M0_RDATA = gnt_rdata;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for timeout, ACK-at-expiry and mid-transaction reset.
module tb_bus_arbiter;

  localparam logic [31:0] M0_ADDR  = 32'h0000_0010;
  localparam logic [31:0] M1_ADDR  = 32'h2000_0004;
  localparam logic [31:0] M1_WDATA = 32'hCAFE_F00D;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic        i_M0_REQ, i_M0_WE, i_M1_REQ, i_M1_WE, i_BUS_ACK;
  logic [31:0] i_M0_ADDR, i_M0_WDATA, i_M1_ADDR, i_M1_WDATA, i_BUS_RDATA;
  logic [1:0]  i_M0_HB, i_M1_HB;
  logic        o_M0_GNT, o_M1_GNT, o_BUS_REQ, o_BUS_WE, o_BUS_ERR;
  logic [31:0] o_M0_RDATA, o_M1_RDATA, o_BUS_ADDR, o_BUS_WDATA;
  logic [1:0]  o_BUS_HB;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_CLK = ~i_CLK;

  bus_arbiter dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_M0_REQ(i_M0_REQ), .i_M0_ADDR(i_M0_ADDR), .i_M0_WDATA(i_M0_WDATA),
    .i_M0_WE(i_M0_WE), .i_M0_HB(i_M0_HB), .o_M0_GNT(o_M0_GNT), .o_M0_RDATA(o_M0_RDATA),
    .i_M1_REQ(i_M1_REQ), .i_M1_ADDR(i_M1_ADDR), .i_M1_WDATA(i_M1_WDATA),
    .i_M1_WE(i_M1_WE), .i_M1_HB(i_M1_HB), .o_M1_GNT(o_M1_GNT), .o_M1_RDATA(o_M1_RDATA),
    .o_BUS_REQ(o_BUS_REQ), .o_BUS_ADDR(o_BUS_ADDR), .o_BUS_WDATA(o_BUS_WDATA),
    .o_BUS_WE(o_BUS_WE), .o_BUS_HB(o_BUS_HB), .i_BUS_RDATA(i_BUS_RDATA),
    .i_BUS_ACK(i_BUS_ACK), .o_BUS_ERR(o_BUS_ERR)
  );

  typedef struct {
    logic        m0;
    logic        m1;
    logic        ack;
    logic [31:0] rd;
    logic        e_breq;
    logic [1:0]  e_own;   // 0 none, 1 M0 drives bus fields, 2 M1 drives bus fields
    logic        e_g0;
    logic        e_g1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_err;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive master requests and slave response at the falling edge, settle, return.
  task automatic step(input logic m0, input logic m1, input logic ack, input logic [31:0] rd);
    @(negedge i_CLK);
    i_M0_REQ    = m0;
    i_M1_REQ    = m1;
    i_BUS_ACK   = ack;
    i_BUS_RDATA = rd;
    #1;
  endtask

  task automatic check_all(input string tag, input logic breq, input logic [1:0] own,
                           input logic g0, input logic g1, input logic [31:0] rd0,
                           input logic [31:0] rd1, input logic err);
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [1:0]  e_hb;
    e_addr  = (own == 2'd1) ? M0_ADDR : (own == 2'd2) ? M1_ADDR : 32'h0;
    e_wdata = (own == 2'd2) ? M1_WDATA : 32'h0;
    e_we    = (own == 2'd2);
    e_hb    = (own != 2'd0) ? 2'b10 : 2'b00;
    chk({tag, ".bus_req"},  {31'h0, o_BUS_REQ}, {31'h0, breq});
    chk({tag, ".bus_addr"}, o_BUS_ADDR, e_addr);
    chk({tag, ".bus_wdata"}, o_BUS_WDATA, e_wdata);
    chk({tag, ".bus_we"},   {31'h0, o_BUS_WE}, {31'h0, e_we});
    chk({tag, ".bus_hb"},   {30'h0, o_BUS_HB}, {30'h0, e_hb});
    chk({tag, ".m0_gnt"},   {31'h0, o_M0_GNT}, {31'h0, g0});
    chk({tag, ".m0_rdata"}, o_M0_RDATA, rd0);
    chk({tag, ".m1_gnt"},   {31'h0, o_M1_GNT}, {31'h0, g1});
    chk({tag, ".m1_rdata"}, o_M1_RDATA, rd1);
    chk({tag, ".bus_err"},  {31'h0, o_BUS_ERR}, {31'h0, err});
    $display("%s: req=%b gnt0=%b gnt1=%b rd0=%h rd1=%h err=%b", tag,
             o_BUS_REQ, o_M0_GNT, o_M1_GNT, o_M0_RDATA, o_M1_RDATA, o_BUS_ERR);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_RST = 1'b1;
    i_M0_REQ = 1'b0; i_M1_REQ = 1'b0; i_BUS_ACK = 1'b0; i_BUS_RDATA = 32'h0;
    i_M0_ADDR = M0_ADDR; i_M0_WDATA = 32'h0;     i_M0_WE = 1'b0; i_M0_HB = 2'b10;
    i_M1_ADDR = M1_ADDR; i_M1_WDATA = M1_WDATA;  i_M1_WE = 1'b1; i_M1_HB = 2'b10;

    // m0 m1 ack rd | breq own g0 g1 rd0 rd1 err
    vecs[0]  = '{0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0}; // post-reset
    // single M0 read, two wait cycles
    vecs[1]  = '{1, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    vecs[2]  = '{1, 0, 0, 32'h0,         1, 2'd1, 0, 0, 32'h0, 32'h0, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,         1, 2'd1, 0, 0, 32'h0, 32'h0, 0};
    vecs[4]  = '{1, 0, 1, 32'h12345678,  1, 2'd1, 1, 0, 32'h12345678, 32'h0, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    // both requesting, zero-wait slave; ACK in IDLE must be ignored
    vecs[6]  = '{1, 1, 1, 32'hA5A5A5A5,  0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    vecs[7]  = '{1, 1, 1, 32'hA5A5A5A5,  1, 2'd2, 0, 1, 32'h0, 32'hA5A5A5A5, 0};
    vecs[8]  = '{1, 1, 1, 32'hA5A5A5A5,  0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
`ifdef BUS_ARB_ROUND_ROBIN_EN
    vecs[9]  = '{1, 1, 1, 32'hA5A5A5A5,  1, 2'd1, 1, 0, 32'hA5A5A5A5, 32'h0, 0};
`else
    vecs[9]  = '{1, 1, 1, 32'hA5A5A5A5,  1, 2'd2, 0, 1, 32'h0, 32'hA5A5A5A5, 0};
`endif
    vecs[10] = '{1, 1, 1, 32'hA5A5A5A5,  0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    vecs[11] = '{1, 1, 1, 32'hA5A5A5A5,  1, 2'd2, 0, 1, 32'h0, 32'hA5A5A5A5, 0};
    vecs[12] = '{0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    // M1 store with one wait cycle
    vecs[13] = '{0, 1, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    vecs[14] = '{0, 1, 0, 32'h0,         1, 2'd2, 0, 0, 32'h0, 32'h0, 0};
    vecs[15] = '{0, 1, 1, 32'h11112222,  1, 2'd2, 0, 1, 32'h0, 32'h11112222, 0};
    vecs[16] = '{0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    // M0 drops its request mid-transaction while the slave ACKs
    vecs[17] = '{1, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0};
    vecs[18] = '{1, 0, 0, 32'h0,         1, 2'd1, 0, 0, 32'h0, 32'h0, 0};
    vecs[19] = '{0, 0, 1, 32'h99999999,  0, 2'd1, 0, 0, 32'h0, 32'h0, 0};
    vecs[20] = '{0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0, 32'h0, 0};

    repeat (3) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].m0, vecs[i].m1, vecs[i].ack, vecs[i].rd);
      check_all($sformatf("vec%0d", i), vecs[i].e_breq, vecs[i].e_own, vecs[i].e_g0,
                vecs[i].e_g1, vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_err);
    end

    // Timeout: slave never ACKs; the 16th owned cycle aborts with error data.
    step(0, 1, 0, 32'h0);
    check_all("to_idle", 0, 2'd0, 0, 0, 32'h0, 32'h0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 0, 32'h0);
      if (k < 16)
        check_all($sformatf("to_wait%0d", k), 1, 2'd2, 0, 0, 32'h0, 32'h0, 0);
      else
        check_all("to_expire", 1, 2'd2, 0, 1, 32'h0, 32'hDEADBEEF, 1);
    end
    step(0, 0, 0, 32'h0);
    check_all("to_after", 0, 2'd0, 0, 0, 32'h0, 32'h0, 0);

    // ACK in the same cycle the timeout would fire: normal completion.
    step(1, 0, 0, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) begin
        step(1, 0, 0, 32'h0);
        if (k == 15)
          check_all("race_wait15", 1, 2'd1, 0, 0, 32'h0, 32'h0, 0);
      end else begin
        step(1, 0, 1, 32'h5A5A0001);
        check_all("race_ack", 1, 2'd1, 1, 0, 32'h5A5A0001, 32'h0, 0);
      end
    end
    step(0, 0, 0, 32'h0);
    check_all("race_after", 0, 2'd0, 0, 0, 32'h0, 32'h0, 0);

    // Reset in the middle of an M0 transaction: no grant afterwards.
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check_all("rst_own", 1, 2'd1, 0, 0, 32'h0, 32'h0, 0);
    i_RST = 1'b1;
    @(negedge i_CLK);
    i_RST       = 1'b0;
    i_BUS_ACK   = 1'b1;
    i_BUS_RDATA = 32'h77777777;
    #1;
    check_all("rst_after", 0, 2'd0, 0, 0, 32'h0, 32'h0, 0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
